// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage types and constants for the RV32I front end.
package fetch_redirect_unit_pkg;

  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0060;
  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_packet_t;

  function automatic logic [31:0] next_fetch_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_skid.sv
// Single-entry holding register for a fetched instruction that decode could not accept.
module fetch_skid_buffer
  import fetch_redirect_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  fetch_packet_t load_pkt,
  input  logic          unload,
  input  logic          clear,
  output fetch_packet_t pkt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt <= '0;
    end else if (clear) begin
      pkt.valid <= 1'b0;
    end else if (load) begin
      pkt <= load_pkt;
    end else if (unload) begin
      pkt.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the PC, runs the I-cache handshake, buffers one instruction
// for a stalled decode, and applies execute-stage redirects with branch statistics.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        is_branch,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic        icache_resp,
  input  logic [31:0] icache_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        flush,
  output logic [31:0] br_total,
  output logic [31:0] br_taken
);

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   req_addr;
  fetch_packet_t out_pkt;
  fetch_packet_t skid_pkt;
  fetch_packet_t skid_in;

  logic        consume;
  logic        redirect;
  logic [31:0] target;
  logic        capture_fetch;
  logic        capture_skid;
  logic        skid_load;
  logic        skid_unload;

  assign consume  = out_pkt.valid && !stall;
  assign redirect = jump_en && !stall;
  assign target   = word_align(jump_addr);
  assign flush    = redirect;

  // Read request and address come only from registers, never from icache_resp.
  assign icache_read    = (state != FULL);
  assign icache_address = req_addr;

  assign instr_valid = out_pkt.valid;
  assign instr       = out_pkt.instr;
  assign instr_pc    = out_pkt.pc;

  always_comb begin
    capture_fetch = 1'b0;
    capture_skid  = 1'b0;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_in       = '{valid: 1'b1, instr: icache_rdata, pc: req_addr};
    unique case (state)
      REQ: begin
        if (icache_resp && !redirect) begin
          capture_fetch = !out_pkt.valid || consume;
          skid_load     = out_pkt.valid && !consume;
        end
      end
      FULL: begin
        capture_skid = consume && skid_pkt.valid && !redirect;
        skid_unload  = consume && !redirect;
      end
      default: ;
    endcase
  end

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .load_pkt (skid_in),
    .unload   (skid_unload),
    .clear    (redirect),
    .pkt      (skid_pkt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      unique case (state)
        REQ: begin
          if (icache_resp) begin
            if (redirect) begin
              pc       <= target;
              req_addr <= target;
            end else begin
              pc       <= next_fetch_addr(req_addr);
              req_addr <= next_fetch_addr(req_addr);
              if (skid_load) state <= FULL;
            end
          end else if (redirect) begin
            // The outstanding read cannot be cancelled; wait for it in DRAIN.
            pc    <= target;
            state <= DRAIN;
          end
        end
        FULL: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= REQ;
          end else if (consume) begin
            state <= REQ;
          end
        end
        DRAIN: begin
          if (redirect) pc <= target;
          if (icache_resp) begin
            req_addr <= redirect ? target : pc;
            state    <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  // A redirect squashes whatever would have been presented at this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pkt <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
    end else if (redirect) begin
      out_pkt.valid <= 1'b0;
      out_pkt.instr <= NOP_INSTR;
    end else if (capture_fetch) begin
      out_pkt <= '{valid: 1'b1, instr: icache_rdata, pc: req_addr};
    end else if (capture_skid) begin
      out_pkt <= skid_pkt;
    end else if (consume) begin
      out_pkt.valid <= 1'b0;
      out_pkt.instr <= NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_total <= '0;
      br_taken <= '0;
    end else begin
      if (is_branch && !stall) br_total <= br_total + 32'd1;
      if (redirect && is_branch) br_taken <= br_taken + 32'd1;
    end
  end

endmodule
